// File: rtl/ula_mul_seq.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier for MULTU.
// Borrows the shared ula32 adder through a request/grant handshake; one ADD per granted cycle.
module ula_mul_seq #(
    parameter logic [2:0] OP_ADD = 3'b010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [2:0]  alu_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_addsub,
    input  logic [31:0] alu_result
);

    localparam int N_ITER = 32;
    localparam logic [4:0] LAST_ITER = 5'(N_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] hi_acc_q, hi_acc_d;
    logic [31:0] lo_acc_q, lo_acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        carry;
    logic [31:0] sum;

    // ALU operands come straight from registers so they stay stable while ungranted.
    assign alu_a      = hi_acc_q;
    assign alu_b      = lo_acc_q[0] ? mcand_q : 32'd0;
    assign alu_ctrl   = OP_ADD;
    assign alu_addsub = 1'b0;

    assign busy    = (state_q == S_RUN);
    assign alu_req = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign hi      = hi_q;
    assign lo      = lo_q;

    // ula32 exposes no carry-out, so recover it from the operand and sum MSBs.
    assign sum   = alu_result;
    assign carry = (alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~sum[31]);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        hi_acc_d = hi_acc_q;
        lo_acc_d = lo_acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mcand_d  = op_a;
                    hi_acc_d = 32'd0;
                    lo_acc_d = op_b;
                    cnt_d    = 5'd0;
                    state_d  = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (alu_gnt) begin
                    hi_acc_d = {carry, sum[31:1]};
                    lo_acc_d = {sum[0], lo_acc_q[31:1]};
                    cnt_d    = cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        hi_d    = {carry, sum[31:1]};
                        lo_d    = {sum[0], lo_acc_q[31:1]};
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= 32'd0;
            hi_acc_q <= 32'd0;
            lo_acc_q <= 32'd0;
            cnt_q    <= 5'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            hi_acc_q <= hi_acc_d;
            lo_acc_q <= lo_acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule
